// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// One radix-2 step per cycle on operand magnitudes; sign and exceptions applied on entry to DONE.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic             start;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mult_sum;
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH:0]   ovf_bits;
  logic [WIDTH-1:0] fin_result;
  logic             fin_exc;

  assign start = ctrl_mult ^ ctrl_div;
  // Unsigned WIDTH bits hold |most negative| exactly, so no wrap on magnitude.
  assign mag_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign mag_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

  // Multiply: shift-add on {hi, lo}; divide: restoring step with hi as remainder, lo as quotient.
  always_comb begin
    addend    = lo_q[0] ? opnd_q : '0;
    mult_sum  = {1'b0, hi_q} + {1'b0, addend};
    rem_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    diff      = {1'b0, rem_shift} - {1'b0, opnd_q};
    ge        = ~diff[WIDTH];
    if (is_div_q) begin
      step_hi = ge ? diff[WIDTH-1:0] : rem_shift;
      step_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = mult_sum[WIDTH:1];
      step_lo = {mult_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_mag = {step_hi, step_lo};
    prod_s   = neg_q ? -prod_mag : prod_mag;
    quo_s    = neg_q ? -step_lo : step_lo;
    ovf_bits = prod_s[2*WIDTH-1:WIDTH-1];
    if (is_div_q) begin
      if (div_zero_q) begin
        fin_result = '0;
        fin_exc    = 1'b1;
      end else begin
        fin_result = quo_s;
        // Only MIN / -1 yields a positive quotient that needs bit WIDTH-1.
        fin_exc    = ~neg_q & step_lo[WIDTH-1];
      end
    end else begin
      fin_result = prod_s[WIDTH-1:0];
      fin_exc    = ~((&ovf_bits) | ~(|ovf_bits));
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    result_d   = result_q;
    exc_d      = exc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRun;
          cnt_d      = '0;
          is_div_d   = ctrl_div;
          neg_d      = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          div_zero_d = (operand_b == '0);
          opnd_d     = ctrl_div ? mag_b : mag_a;
          hi_d       = '0;
          lo_d       = ctrl_div ? mag_a : mag_b;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          result_d = fin_result;
          exc_d    = fin_exc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      result_q   <= '0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
    end
  end

  assign busy       = (state_q == StRun);
  assign result_rdy = (state_q == StDone);
  assign result     = result_q;
  assign exception  = exc_q;

endmodule
